cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
Complete-stage arbiter that sits directly downstream of the FU bank. It receives one result per FU each cycle and grants up to NUM_CDB of them onto the common data bus, with one registered stage between grant and bus. It drives the per-FU full_hazard back to the FUs so that un-granted results are held in place. The registered CDB entries feed the physical register file write port, the RS wakeup logic and the ROB complete logic.

Parameters:
NUM_FU, 5, number of FU result sources; index NUM_FU-1 is the highest-numbered ALU.
NUM_CDB, 2, CDB broadcast slots per cycle; 1 <= NUM_CDB <= NUM_FU.
NUM_PR, 64, physical registers; T_idx width is $clog2(NUM_PR).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
fu_done  in  NUM_FU  FU i holds a valid result this cycle
fu_T_idx  in  NUM_FU*$clog2(NUM_PR)  destination physical register per FU
fu_result  in  NUM_FU*64  result value per FU
rollback_en  in  1  branch-mispredict flush
full_hazard  out  NUM_FU  FU i's result was not taken this cycle; FU must hold its output
cdb_valid  out  NUM_CDB  CDB slot k carries a result (registered)
cdb_T_idx  out  NUM_CDB*$clog2(NUM_PR)  CDB slot k tag (registered)
cdb_result  out  NUM_CDB*64  CDB slot k value (registered)

Behaviour:
- Clock and reset: clock is `clock`; reset is `reset`, synchronous, active-high.
- Reset values: cdb_valid=0, cdb_T_idx=0, cdb_result=0, rr_ptr=0. While reset is high, there are no grants and full_hazard=0.
- State: rr_ptr, $clog2(NUM_FU) bits, range 0..NUM_FU-1. Requesters are scanned in the order rr_ptr, rr_ptr+1, ... mod NUM_FU.
- Grant (combinational): the first NUM_CDB requesters with fu_done=1 in scan order are granted. The j-th granted requester in scan order maps to CDB slot j.
- full_hazard[i] = fu_done[i] & ~grant[i], combinational in the same cycle. It is never asserted for an FU with fu_done=0.
- Latency: a result granted in cycle N appears on cdb_* in cycle N+1 and is valid for exactly one cycle. Unused slots get cdb_valid=0; their T_idx and result hold their previous values.
- Pointer update: if any grant is made, rr_ptr <= (index of last granted FU + 1) mod NUM_FU. With no grant, rr_ptr holds.
- Fairness: an FU requesting continuously is granted within ceil(NUM_FU/NUM_CDB) cycles.
- Held result: a held FU re-presents the same T_idx/result. The arbiter does not latch requests; each cycle is arbitrated fresh.
- rollback_en=1: no grants, full_hazard=0 (the FUs flush the same cycle), cdb_valid<=0 next cycle, rr_ptr holds.
- rollback_en has priority over requests. reset has priority over rollback_en.
- No duplicate-tag check; each T_idx has a single in-flight producer by construction.
- Width rules: index arithmetic is mod NUM_FU with no overflow into unused pointer codes. NUM_FU not a power of two must be handled.

Decomposition:
- Shared package: CDB_ENTRY_t {valid, T_idx, result}, CDB_PACKET_OUT_t (CDB_ENTRY_t [NUM_CDB-1:0]), and the `NUM_CDB define, alongside `NUM_FU/`NUM_PR.
- One sub-module, rr_pick_n: combinational rotating-priority picker.
  - Inputs: req[NUM_FU], ptr.
  - Outputs: grant[NUM_FU], per-slot one-hot select, last-granted index.
- The top level holds rr_ptr, the output registers and the hazard logic.

Test Plan:
- Reset, with fu_done=5'b11111 for 2 cycles -> full_hazard=0 and cdb_valid=00 throughout. After release, the first grant goes to FU0,FU1 (rr_ptr=0).
- Single request: FU2, T_idx=7, result=0x1234, rr_ptr=0 -> full_hazard=0 that cycle. Next cycle cdb_valid=01, slot0 T_idx=7, result=0x1234; rr_ptr=3.
- Over-subscription, rr_ptr=0, fu_done={FU0,FU1,FU3} -> grant FU0 to slot0 and FU1 to slot1; full_hazard=5'b01000; rr_ptr=2. Next cycle FU3 (still presenting) is granted to slot0 and cdb shows FU0/FU1.
- Wrap-around, rr_ptr=4, fu_done={FU4,FU0,FU1} -> slot0=FU4, slot1=FU0; full_hazard[1]=1; rr_ptr=1.
- Flush: rollback_en=1 with fu_done=5'b10101 -> full_hazard=0, next-cycle cdb_valid=00, rr_ptr unchanged.
- Fairness: all FUs requesting for 5 cycles starting at rr_ptr=0 -> grant pairs (0,1),(2,3),(4,0),(1,2),(3,4). Each FU is granted exactly twice and rr_ptr returns to 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the complete-stage CDB arbiter.
// The legacy defines remain the single source of truth for FU/CDB/PR counts.
`ifndef NUM_FU
`define NUM_FU 5
`endif
`ifndef NUM_CDB
`define NUM_CDB 2
`endif
`ifndef NUM_PR
`define NUM_PR 64
`endif

package cdb_arbiter_pkg;

  localparam int unsigned NUM_FU   = `NUM_FU;
  localparam int unsigned NUM_CDB  = `NUM_CDB;
  localparam int unsigned NUM_PR   = `NUM_PR;
  localparam int unsigned XLEN     = 64;
  localparam int unsigned TAG_W    = $clog2(NUM_PR);
  localparam int unsigned FU_IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] T_idx;
    logic [XLEN-1:0]  result;
  } CDB_ENTRY_t;

  typedef CDB_ENTRY_t [NUM_CDB-1:0] CDB_PACKET_OUT_t;

  // Increment an FU index modulo NUM_FU without touching unused pointer codes.
  function automatic logic [FU_IDX_W-1:0] fu_idx_inc(input logic [FU_IDX_W-1:0] idx);
    if (idx == FU_IDX_W'(NUM_FU - 1)) begin
      return '0;
    end
    return idx + FU_IDX_W'(1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-bank to CDB arbiter bundle: per-FU results and hazards, registered CDB slots.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic [NUM_FU-1:0]       fu_done;
  logic [NUM_FU*TAG_W-1:0] fu_T_idx;
  logic [NUM_FU*XLEN-1:0]  fu_result;
  logic                    rollback_en;
  logic [NUM_FU-1:0]       full_hazard;
  logic [NUM_CDB-1:0]      cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_T_idx;
  logic [NUM_CDB*XLEN-1:0] cdb_result;

  modport master (
    output fu_done, fu_T_idx, fu_result, rollback_en,
    input  full_hazard, cdb_valid, cdb_T_idx, cdb_result
  );

  modport slave (
    input  fu_done, fu_T_idx, fu_result, rollback_en,
    output full_hazard, cdb_valid, cdb_T_idx, cdb_result
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick_n.sv
// Combinational rotating-priority picker: grants the first NUM_CDB requesters
// scanning from i_ptr upward modulo NUM_FU; the j-th grant lands in slot j.
module rr_pick_n #(
  parameter  int unsigned NUM_FU  = 5,
  parameter  int unsigned NUM_CDB = 2,
  localparam int unsigned IDX_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0]              i_req,
  input  logic [IDX_W-1:0]               i_ptr,
  output logic [NUM_FU-1:0]              o_grant,
  output logic [NUM_CDB-1:0][NUM_FU-1:0] o_sel,
  output logic [IDX_W-1:0]               o_last
);

  localparam int unsigned SLOT_W = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

  // i_ptr is always < NUM_FU, so a single conditional subtract wraps the scan index.
  always_comb begin
    int unsigned cnt;
    int unsigned idx;
    o_grant = '0;
    o_sel   = '0;
    o_last  = '0;
    cnt     = 0;
    idx     = 0;
    for (int unsigned off = 0; off < NUM_FU; off++) begin
      idx = 32'(i_ptr) + off;
      if (idx >= NUM_FU) begin
        idx = idx - NUM_FU;
      end
      if (i_req[IDX_W'(idx)] && (cnt < NUM_CDB)) begin
        o_grant[IDX_W'(idx)]             = 1'b1;
        o_sel[SLOT_W'(cnt)][IDX_W'(idx)] = 1'b1;
        o_last                           = IDX_W'(idx);
        cnt                              = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Complete-stage arbiter: picks up to NUM_CDB FU results per cycle, registers
// them onto the CDB, and back-pressures un-granted FUs via full_hazard.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input logic          clock,
  input logic          reset,
  cdb_arbiter_if.slave bus
);

  logic                              w_arb_en;
  logic [NUM_FU-1:0]                 w_req;
  logic [NUM_FU-1:0]                 w_grant;
  logic [NUM_CDB-1:0][NUM_FU-1:0]    w_sel;
  logic [FU_IDX_W-1:0]               w_last;
  logic [FU_IDX_W-1:0]               r_rr_ptr;
  CDB_PACKET_OUT_t                   r_cdb;
  CDB_PACKET_OUT_t                   w_cdb_next;

  // Reset beats flush, flush beats requests: either one masks all requests.
  assign w_arb_en = ~reset & ~bus.rollback_en;
  assign w_req    = bus.fu_done & {NUM_FU{w_arb_en}};

  rr_pick_n #(
    .NUM_FU  (NUM_FU),
    .NUM_CDB (NUM_CDB)
  ) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_sel   (w_sel),
    .o_last  (w_last)
  );

  assign bus.full_hazard = w_req & ~w_grant;

  // Unused slots drop valid but keep their last tag/result.
  always_comb begin
    w_cdb_next = r_cdb;
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      w_cdb_next[k].valid = 1'b0;
      for (int i = 0; i < int'(NUM_FU); i++) begin
        if (w_sel[k][i]) begin
          w_cdb_next[k].valid  = 1'b1;
          w_cdb_next[k].T_idx  = bus.fu_T_idx[i*TAG_W +: TAG_W];
          w_cdb_next[k].result = bus.fu_result[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cdb    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_cdb <= w_cdb_next;
      if (|w_grant) begin
        r_rr_ptr <= fu_idx_inc(w_last);
      end
    end
  end

  always_comb begin
    bus.cdb_valid  = '0;
    bus.cdb_T_idx  = '0;
    bus.cdb_result = '0;
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      bus.cdb_valid[k]                  = r_cdb[k].valid;
      bus.cdb_T_idx[k*TAG_W +: TAG_W]   = r_cdb[k].T_idx;
      bus.cdb_result[k*XLEN +: XLEN]    = r_cdb[k].result;
    end
  end

endmodule
